scan_accumulator: RTL and testbench
===================================

Name: scan_accumulator

Overview:
- Sits directly downstream of the operations block; consumes its decimated receiver output: data_in_i/data_in_q, 4 lanes x 16-bit signed per beat, qualified by data_valid.
- Coherently averages a phase-cycled multi-scan NMR run into on-chip accumulation RAM. Each scan is added or subtracted according to the receiver phase-cycle sign.
- The host reads the finished FID record back through a simple synchronous read port.

Parameters:
- LANES, 4, samples per beat per channel.
- SAMPLE_W, 16, signed input sample width.
- ACC_W, 32, signed accumulator width per sample.
- DEPTH, 1024, beats stored per scan.
- ADDR_W, 10, clog2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_start  in  1  pulse: clear scan counter and flags, arm for a new run.
- num_scans  in  16  scans per run, sampled on run_start; 0 is treated as 1.
- scan_start  in  1  pulse: begin capturing one scan (driven at pulse-program start).
- scan_subtract  in  1  sampled on scan_start; 1 = subtract this scan (180-degree RX cycle).
- data_in_i  in  LANES*SAMPLE_W  I samples; lane 0 in the LSBs.
- data_in_q  in  LANES*SAMPLE_W  Q samples; same lane order as data_in_i.
- data_valid  in  1  qualifies data_in_i/data_in_q.
- rd_en  in  1  host read request.
- rd_addr  in  ADDR_W  host read beat address.
- rd_data_i  out  LANES*ACC_W  accumulated I for rd_addr.
- rd_data_q  out  LANES*ACC_W  accumulated Q for rd_addr.
- rd_valid  out  1  rd_data_i/rd_data_q valid.
- busy  out  1  high in ARMED, ACQ and FLUSH.
- done  out  1  high in DONE.
- scan_count  out  16  scans completed in the current run.
- overflow  out  1  sticky; set when any accumulation saturates.

Behaviour:
- Reset values: all outputs 0; state IDLE; write address 0.
- States and transitions:
  - IDLE -> ARMED on run_start.
  - ARMED -> ACQ on scan_start.
  - ACQ: each data_valid beat performs a read-modify-write at write address wa, then wa increments.
  - ACQ -> FLUSH when the DEPTH-th beat is accepted.
  - FLUSH: waits 2 cycles for the RMW pipeline to drain, then increments scan_count.
  - FLUSH -> DONE if scan_count reaches num_scans, else -> ARMED.
  - DONE -> ARMED on run_start (counters cleared, as from IDLE).
- RMW pipeline:
  - Cycle 0: RAM read at wa.
  - Cycle 1: per-lane add or subtract of the sign-extended sample.
  - Cycle 2: write back.
  - Write latency is 2 cycles. Consecutive beats hit distinct addresses, so no forwarding is needed within a scan.
- First scan of a run (scan_count = 0): the RAM old value is treated as 0. This replaces a clear pass.
- Subtract: acc - sext(sample). With scan_subtract on the first scan, the result is -sext(sample).
- Saturation with ACC_SATURATE_EN: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set overflow.
- Ignored inputs:
  - data_valid outside ACQ, including beats beyond DEPTH.
  - scan_start outside ARMED.
  - run_start while in ACQ or FLUSH.
- rd_en:
  - Honoured in IDLE, ARMED and DONE; rd_valid is asserted 1 cycle later with the data.
  - Ignored in ACQ/FLUSH: rd_valid stays 0 and rd_data holds its last value.
- Simultaneous run_start and scan_start in IDLE: run_start wins; scan_start is dropped.
- rst_n low mid-run: state returns to IDLE and all outputs to 0; RAM contents are undefined. The next run overwrites RAM via the first-scan rule.

Optional Feature:
- Macro: ACC_SATURATE_EN
- Defined: saturating per-lane arithmetic; overflow is a sticky flag, cleared by run_start or reset.
- Undefined: two's-complement wrap-around; overflow is tied to 0; the clamp logic is removed.

Test Plan:
- Single scan, add: run_start with num_scans=1, scan_start with subtract=0, 1024 beats of lane values {1,2,3,4} on I and {-1,-2,-3,-4} on Q -> done=1, scan_count=1; reading any address gives I {1,2,3,4} and Q {-1,-2,-3,-4}.
- Four-scan phase cycle: num_scans=4, signs add,sub,add,sub, input I sample per scan 100, -100, 100, -100 -> every lane reads 400.
- Stale RAM: run A leaves 400 in RAM; run B with num_scans=1 and sample 7 -> reads 7, not 407.
- Boundaries: 1030 beats in one scan -> only 1024 are stored and scan_count increments once. scan_start sent during ACQ -> ignored. rd_en during ACQ -> rd_valid=0.
- Saturation (ACC_SATURATE_EN): ACC_W=16, num_scans=3, sample 16000 -> reads 32767 and overflow=1. With the macro undefined -> reads -17536 and overflow=0.
- Async reset: rst_n pulsed low mid-ACQ -> busy, done, scan_count and rd_valid are 0 immediately. A following run_start/scan sequence completes correctly.

Source files
------------

// File: rtl/scan_accumulator.sv
`timescale 1ns/1ps
// scan_accumulator
// ----------------
// Coherent multi-scan averager for a phase-cycled NMR receiver. Each scan of
// DEPTH beats (LANES I/Q samples per beat) is added to or subtracted from an
// on-chip accumulation RAM through a three-stage read-modify-write pipeline.
// The first scan of a run ignores whatever the RAM holds, so no clear pass is
// needed. The host reads the finished record through a registered read port.
//
// Optional build macro: ACC_SATURATE_EN
//   defined   -> per-lane saturating arithmetic, sticky overflow flag
//   undefined -> two's-complement wrap-around, overflow tied to 0
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   run_start      pulse: clear scan counter/flags and arm a new run
//   num_scans      scans per run, sampled on run_start (0 behaves as 1)
//   scan_start     pulse: begin capturing one scan (honoured in ARMED only)
//   scan_subtract  sampled with scan_start; 1 = subtract this scan
//   data_in_i/q    LANES x SAMPLE_W signed samples, lane 0 in the LSBs
//   data_valid     qualifies data_in_i/q
//   rd_en/rd_addr  host read request and beat address
//   rd_data_i/q    accumulated LANES x ACC_W values, valid with rd_valid
//   busy           high in ARMED, ACQ and FLUSH
//   done           high in DONE
//   scan_count     scans completed in the current run
//   overflow       sticky saturation flag
module scan_accumulator #(
  parameter int LANES    = 4,
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run_start,
  input  logic [15:0]               num_scans,
  input  logic                      scan_start,
  input  logic                      scan_subtract,
  input  logic [LANES*SAMPLE_W-1:0] data_in_i,
  input  logic [LANES*SAMPLE_W-1:0] data_in_q,
  input  logic                      data_valid,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [LANES*ACC_W-1:0]    rd_data_i,
  output logic [LANES*ACC_W-1:0]    rd_data_q,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               scan_count,
  output logic                      overflow
);

  typedef enum logic [2:0] {IDLE, ARMED, ACQ, FLUSH, DONE} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] wa;
  logic [15:0]       target;
  logic              flush_cnt;
  logic              scan_sub;

  logic run_ok, scan_go, beat_accept, last_beat, flush_end, rd_ok;

  // Pipeline stage 1: captured beat waiting for its RAM read data
  logic                      s1_valid, s1_sub, s1_first;
  logic [ADDR_W-1:0]         s1_addr;
  logic [LANES*SAMPLE_W-1:0] s1_i, s1_q;
  logic [LANES*ACC_W-1:0]    old_i, old_q;

  // Pipeline stage 2: updated accumulators waiting to be written back
  logic                      s2_valid;
  logic [ADDR_W-1:0]         s2_addr;
  logic [LANES*ACC_W-1:0]    s2_i, s2_q;
  logic [LANES*ACC_W-1:0]    new_i, new_q;

  logic [LANES*ACC_W-1:0] mem_i [DEPTH];
  logic [LANES*ACC_W-1:0] mem_q [DEPTH];

  // run_start is only accepted when no scan is in flight; it beats a
  // coincident scan_start so a run always begins from a clean ARMED state.
  assign run_ok      = run_start && (state == IDLE || state == ARMED || state == DONE);
  assign scan_go     = (state == ARMED) && scan_start && !run_start;
  assign beat_accept = (state == ACQ) && data_valid;
  assign last_beat   = beat_accept && (wa == ADDR_W'(DEPTH - 1));
  assign flush_end   = (state == FLUSH) && flush_cnt;
  assign rd_ok       = rd_en && (state == IDLE || state == ARMED || state == DONE);

  assign busy = (state == ARMED) || (state == ACQ) || (state == FLUSH);
  assign done = (state == DONE);

  // Next-state logic. FLUSH lasts two cycles so the final write-back lands
  // on the same edge that leaves FLUSH.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (run_start) state_next = ARMED;
      ARMED: if (run_ok) state_next = ARMED;
             else if (scan_go) state_next = ACQ;
      ACQ:   if (last_beat) state_next = FLUSH;
      FLUSH: if (flush_cnt) state_next = ((scan_count + 16'd1) == target) ? DONE : ARMED;
      DONE:  if (run_start) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  // Control registers: state, write address, run bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wa         <= '0;
      scan_count <= '0;
      target     <= 16'd1;
      flush_cnt  <= 1'b0;
      scan_sub   <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
      if (run_ok) begin
        scan_count <= '0;
        target     <= (num_scans == 16'd0) ? 16'd1 : num_scans;
      end else if (flush_end) begin
        scan_count <= scan_count + 16'd1;
      end
      if (scan_go) begin
        wa       <= '0;
        scan_sub <= scan_subtract;
      end else if (beat_accept) begin
        wa <= last_beat ? '0 : wa + ADDR_W'(1);
      end
    end
  end

  // Read-modify-write pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sub   <= 1'b0;
      s1_first <= 1'b0;
      s1_addr  <= '0;
      s1_i     <= '0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_i     <= '0;
      s2_q     <= '0;
    end else begin
      s1_valid <= beat_accept;
      if (beat_accept) begin
        s1_sub   <= scan_sub;
        s1_first <= (scan_count == 16'd0);
        s1_addr  <= wa;
        s1_i     <= data_in_i;
        s1_q     <= data_in_q;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_i    <= new_i;
        s2_q    <= new_q;
      end
    end
  end

  // Accumulation RAM: write-back port plus the pipeline's read port
  always_ff @(posedge clk) begin
    if (s2_valid) begin
      mem_i[s2_addr] <= s2_i;
      mem_q[s2_addr] <= s2_q;
    end
    if (beat_accept) begin
      old_i <= mem_i[wa];
      old_q <= mem_q[wa];
    end
  end

  // Host read port; output registers hold their value while ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_data_i <= '0;
      rd_data_q <= '0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data_i <= mem_i[rd_addr];
        rd_data_q <= mem_q[rd_addr];
      end
    end
  end

`ifdef ACC_SATURATE_EN
  logic ovf_beat;

  // Returns {overflow, clamped value}; one guard bit detects saturation.
  function automatic logic [ACC_W:0] lane_update(input logic [ACC_W-1:0]    old,
                                                 input logic [SAMPLE_W-1:0] smp,
                                                 input logic                sub,
                                                 input logic                first);
    logic signed [ACC_W:0] a, b, s;
    a = first ? '0 : (ACC_W+1)'($signed(old));
    b = (ACC_W+1)'($signed(smp));
    s = sub ? a - b : a + b;
    if (s[ACC_W] != s[ACC_W-1])
      lane_update = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    else
      lane_update = {1'b0, s[ACC_W-1:0]};
  endfunction

  // Per-lane saturating add/subtract for both channels
  always_comb begin
    logic [ACC_W:0] res_i, res_q;
    res_i    = '0;
    res_q    = '0;
    new_i    = '0;
    new_q    = '0;
    ovf_beat = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      res_i = lane_update(old_i[k*ACC_W +: ACC_W], s1_i[k*SAMPLE_W +: SAMPLE_W], s1_sub, s1_first);
      res_q = lane_update(old_q[k*ACC_W +: ACC_W], s1_q[k*SAMPLE_W +: SAMPLE_W], s1_sub, s1_first);
      new_i[k*ACC_W +: ACC_W] = res_i[ACC_W-1:0];
      new_q[k*ACC_W +: ACC_W] = res_q[ACC_W-1:0];
      ovf_beat = ovf_beat | res_i[ACC_W] | res_q[ACC_W];
    end
  end

  // Sticky overflow, cleared only when a new run is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (run_ok)
      overflow <= 1'b0;
    else if (s1_valid && ovf_beat)
      overflow <= 1'b1;
  end
`else
  // Plain two's-complement accumulate; wrap-around is the intended result.
  function automatic logic [ACC_W-1:0] lane_update(input logic [ACC_W-1:0]    old,
                                                   input logic [SAMPLE_W-1:0] smp,
                                                   input logic                sub,
                                                   input logic                first);
    logic signed [ACC_W-1:0] a, b;
    a = first ? '0 : $signed(old);
    b = ACC_W'($signed(smp));
    lane_update = sub ? a - b : a + b;
  endfunction

  // Per-lane wrapping add/subtract for both channels
  always_comb begin
    new_i = '0;
    new_q = '0;
    for (int k = 0; k < LANES; k++) begin
      new_i[k*ACC_W +: ACC_W] = lane_update(old_i[k*ACC_W +: ACC_W], s1_i[k*SAMPLE_W +: SAMPLE_W], s1_sub, s1_first);
      new_q[k*ACC_W +: ACC_W] = lane_update(old_q[k*ACC_W +: ACC_W], s1_q[k*SAMPLE_W +: SAMPLE_W], s1_sub, s1_first);
    end
  end

  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_scan_accumulator.sv
`timescale 1ns/1ps
// Testbench for scan_accumulator: table of multi-scan runs with host reads
// checked through a scoreboard, plus hand sequences for beat overrun,
// ignored controls, asynchronous reset and accumulator wrap/saturation.
module tb_scan_accumulator;

  localparam int LANES    = 4;
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 32;
  localparam int DEPTH    = 1024;
  localparam int ADDR_W   = 10;

`ifdef ACC_SATURATE_EN
  localparam logic [15:0] SM_EXP_I   = 16'h7FFF;
  localparam logic [15:0] SM_EXP_Q   = 16'h8000;
  localparam logic        SM_EXP_OVF = 1'b1;
`else
  localparam logic [15:0] SM_EXP_I   = 16'hBB80;
  localparam logic [15:0] SM_EXP_Q   = 16'h4480;
  localparam logic        SM_EXP_OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic run_start, scan_start, scan_subtract, data_valid, rd_en;
  logic [15:0] num_scans;
  logic [LANES*SAMPLE_W-1:0] data_in_i, data_in_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [LANES*ACC_W-1:0] rd_data_i, rd_data_q;
  logic rd_valid, busy, done, overflow;
  logic [15:0] scan_count;

  // Small instance with 16-bit accumulators for the wrap/saturation case
  logic sm_run_start, sm_scan_start, sm_valid, sm_rd_en;
  logic [15:0] sm_num_scans, sm_scan_count;
  logic [63:0] sm_data_i, sm_data_q, sm_rd_data_i, sm_rd_data_q;
  logic [2:0] sm_rd_addr;
  logic sm_rd_valid, sm_busy, sm_done, sm_overflow;

  int n_checks = 0;
  int n_fail = 0;
  logic [127:0] sb_i[$];
  logic [127:0] sb_q[$];
  logic [127:0] exp_i_m, exp_q_m;

  typedef struct {
    int              num;
    int              eff;
    logic [3:0]      subs;
    logic [3:0][15:0] samp;
    int              expv;
  } run_vec_t;

  run_vec_t runs[5];
  int rd_addrs[4] = '{0, 1, 517, 1023};

  always #5 clk = ~clk;

  scan_accumulator dut (
    .clk(clk), .rst_n(rst_n), .run_start(run_start), .num_scans(num_scans),
    .scan_start(scan_start), .scan_subtract(scan_subtract),
    .data_in_i(data_in_i), .data_in_q(data_in_q), .data_valid(data_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_i(rd_data_i), .rd_data_q(rd_data_q),
    .rd_valid(rd_valid), .busy(busy), .done(done), .scan_count(scan_count),
    .overflow(overflow)
  );

  scan_accumulator #(.ACC_W(16), .DEPTH(8), .ADDR_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .run_start(sm_run_start), .num_scans(sm_num_scans),
    .scan_start(sm_scan_start), .scan_subtract(1'b0),
    .data_in_i(sm_data_i), .data_in_q(sm_data_q), .data_valid(sm_valid),
    .rd_en(sm_rd_en), .rd_addr(sm_rd_addr), .rd_data_i(sm_rd_data_i), .rd_data_q(sm_rd_data_q),
    .rd_valid(sm_rd_valid), .busy(sm_busy), .done(sm_done), .scan_count(sm_scan_count),
    .overflow(sm_overflow)
  );

  function automatic logic [63:0] beat_of(input int v);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*16 +: 16] = 16'(v * (k + 1));
    return r;
  endfunction

  function automatic logic [127:0] acc_of(input int v);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*32 +: 32] = 32'(v * (k + 1));
    return r;
  endfunction

  function automatic run_vec_t make_run(input int num, input int eff, input logic [3:0] subs,
                                        input int a, input int b, input int c, input int d,
                                        input int expv);
    run_vec_t v;
    v.num = num; v.eff = eff; v.subs = subs; v.expv = expv;
    v.samp[0] = 16'(a); v.samp[1] = 16'(b); v.samp[2] = 16'(c); v.samp[3] = 16'(d);
    return v;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n);
    run_start = 1'b1;
    num_scans = 16'(n);
    tick();
    run_start = 1'b0;
  endtask

  // Drive one scan; inject exercises controls that must be ignored mid-scan
  task automatic apply_stimulus(input logic sub, input int v, input int nbeats, input bit inject);
    scan_start = 1'b1;
    scan_subtract = sub;
    tick();
    scan_start = 1'b0;
    scan_subtract = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      data_valid = 1'b1;
      data_in_i = beat_of(v);
      data_in_q = beat_of(-v);
      if (inject && b == 300) begin rd_en = 1'b1; rd_addr = '0; end
      if (inject && b == 500) begin scan_start = 1'b1; scan_subtract = 1'b1; end
      if (inject && (b == 700 || b == 1025)) begin run_start = 1'b1; num_scans = 16'd5; end
      tick();
      if (inject && b == 300) check_output("rd_valid_during_acq", 128'(rd_valid), 128'(0));
      rd_en = 1'b0;
      scan_start = 1'b0;
      scan_subtract = 1'b0;
      run_start = 1'b0;
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_count(input logic [15:0] n);
    int cyc;
    cyc = 0;
    while (scan_count != n && cyc < 40) begin
      tick();
      cyc++;
    end
    check_output("scan_count", 128'(scan_count), 128'(n));
  endtask

  task automatic host_read(input int addr, input logic [127:0] ei, input logic [127:0] eq);
    rd_en = 1'b1;
    rd_addr = ADDR_W'(addr);
    sb_i.push_back(ei);
    sb_q.push_back(eq);
    tick();
    rd_en = 1'b0;
  endtask

  // Scoreboard: every rd_valid beat must match the oldest pending read
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb_i.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_rd_valid: got rd_valid=1 with no read pending");
      end else begin
        exp_i_m = sb_i.pop_front();
        exp_q_m = sb_q.pop_front();
        check_output("rd_data_i", rd_data_i, exp_i_m);
        check_output("rd_data_q", rd_data_q, exp_q_m);
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    runs[0] = make_run(1, 1, 4'b0000,    1,    0,   0,    0,   1);
    runs[1] = make_run(4, 4, 4'b1010,  100, -100, 100, -100, 400);
    runs[2] = make_run(1, 1, 4'b0000,    7,    0,   0,    0,   7);
    runs[3] = make_run(2, 2, 4'b0001,    5,    3,   0,    0,  -2);
    runs[4] = make_run(0, 1, 4'b0001,   -9,    0,   0,    0,   9);

    rst_n = 1'b0;
    run_start = 0; scan_start = 0; scan_subtract = 0; data_valid = 0; rd_en = 0;
    num_scans = '0; data_in_i = '0; data_in_q = '0; rd_addr = '0;
    sm_run_start = 0; sm_scan_start = 0; sm_valid = 0; sm_rd_en = 0;
    sm_num_scans = '0; sm_data_i = '0; sm_data_q = '0; sm_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", 128'(busy), 128'(0));
    check_output("reset_done", 128'(done), 128'(0));
    check_output("reset_scan_count", 128'(scan_count), 128'(0));
    check_output("reset_rd_valid", 128'(rd_valid), 128'(0));
    check_output("reset_overflow", 128'(overflow), 128'(0));
    check_output("reset_rd_data_i", rd_data_i, 128'(0));
    check_output("reset_rd_data_q", rd_data_q, 128'(0));
    rst_n = 1'b1;
    tick();

    // Run table: each entry is a full run followed by scoreboarded reads
    for (int r = 0; r < 5; r++) begin
      start_run(runs[r].num);
      check_output("busy_armed", 128'(busy), 128'(1));
      for (int s = 0; s < runs[r].eff; s++) begin
        apply_stimulus(runs[r].subs[s], int'($signed(runs[r].samp[s])), DEPTH, 1'b0);
        wait_count(16'(s + 1));
      end
      check_output("run_done", 128'(done), 128'(1));
      check_output("run_busy", 128'(busy), 128'(0));
      check_output("run_overflow", 128'(overflow), 128'(0));
      foreach (rd_addrs[a]) host_read(rd_addrs[a], acc_of(runs[r].expv), acc_of(-runs[r].expv));
      tick();
    end

    // Beat overrun and ignored scan_start/run_start/rd_en during a scan
    start_run(2);
    apply_stimulus(1'b0, 11, 1030, 1'b0);
    wait_count(16'd1);
    check_output("overrun_busy", 128'(busy), 128'(1));
    check_output("overrun_done", 128'(done), 128'(0));
    apply_stimulus(1'b0, 11, 1030, 1'b1);
    wait_count(16'd2);
    check_output("overrun_done2", 128'(done), 128'(1));
    host_read(0, acc_of(22), acc_of(-22));
    host_read(1023, acc_of(22), acc_of(-22));
    tick();

    // Asynchronous reset in the middle of the second scan
    start_run(2);
    apply_stimulus(1'b0, 3, DEPTH, 1'b0);
    wait_count(16'd1);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    data_valid = 1'b1;
    data_in_i = beat_of(3);
    data_in_q = beat_of(-3);
    repeat (200) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_busy", 128'(busy), 128'(0));
    check_output("areset_done", 128'(done), 128'(0));
    check_output("areset_scan_count", 128'(scan_count), 128'(0));
    check_output("areset_rd_valid", 128'(rd_valid), 128'(0));
    data_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // run_start and scan_start together in IDLE: only the run is armed
    run_start = 1'b1;
    scan_start = 1'b1;
    num_scans = 16'd1;
    tick();
    run_start = 1'b0;
    scan_start = 1'b0;
    data_valid = 1'b1;
    data_in_i = beat_of(50);
    data_in_q = beat_of(-50);
    repeat (DEPTH) tick();
    data_valid = 1'b0;
    repeat (3) tick();
    check_output("simul_scan_count", 128'(scan_count), 128'(0));
    check_output("simul_busy", 128'(busy), 128'(1));
    apply_stimulus(1'b0, 13, DEPTH, 1'b0);
    wait_count(16'd1);
    check_output("post_reset_done", 128'(done), 128'(1));
    host_read(0, acc_of(13), acc_of(-13));
    host_read(700, acc_of(13), acc_of(-13));
    tick();

    // 16-bit accumulators: three scans of 16000 exceed the range
    sm_run_start = 1'b1;
    sm_num_scans = 16'd3;
    tick();
    sm_run_start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sm_scan_start = 1'b1;
      tick();
      sm_scan_start = 1'b0;
      sm_valid = 1'b1;
      sm_data_i = {4{16'h3E80}};
      sm_data_q = {4{16'hC180}};
      repeat (8) tick();
      sm_valid = 1'b0;
      repeat (3) tick();
    end
    check_output("small_done", 128'(sm_done), 128'(1));
    check_output("small_scan_count", 128'(sm_scan_count), 128'(3));
    check_output("small_overflow", 128'(sm_overflow), 128'(SM_EXP_OVF));
    sm_rd_en = 1'b1;
    sm_rd_addr = 3'd5;
    tick();
    sm_rd_en = 1'b0;
    check_output("small_rd_valid", 128'(sm_rd_valid), 128'(1));
    check_output("small_rd_data_i", 128'(sm_rd_data_i), 128'({4{SM_EXP_I}}));
    check_output("small_rd_data_q", 128'(sm_rd_data_q), 128'({4{SM_EXP_Q}}));

    tick();
    check_output("scoreboard_drained", 128'(sb_i.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
